multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: ALUCTRL_W, 3, ALUControl width; codes zero-extended when ALUCTRL_W > 3 (ALUCTRL_W >= 3 SHALL hold).
REQ-002 Parameter: EN_BNE, 1, when 1 the block SHALL decode BNE (funct3=001); when 0, BNE SHALL be illegal.
REQ-003 Parameter: MEM_WAIT, 1, when 1 memory states SHALL wait for mem_ready; when 0, mem_ready SHALL be treated as constant 1.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 instr  in  32  instruction register contents, stable from DECODE until return to FETCH.
REQ-008 zero_flg  in  1  ALU zero result.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  PC enable, IR enable, memory write, register-file write, address select (0=PC, 1=Result).
REQ-011 ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALUResult.
REQ-012 ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1.
REQ-013 ALUSrcB  out  2  00=rs2, 01=imm, 10=constant 4.
REQ-014 ImmSrc  out  2  00=I, 01=S, 10=B, 11=J.
REQ-015 ALUControl  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 illegal_instr  out  1  one-cycle pulse on an undecodable instruction.
REQ-017 state_o  out  4  current state encoding, for debug.

Function
REQ-018 Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, JAL, BRANCH, ILLEGAL; unlisted outputs SHALL be 0.
REQ-019 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay until mem_ready, then DECODE.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add; next: opcode 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1101111->JAL, 1100011->BRANCH, others->ILLEGAL.
REQ-021 BRANCH SHALL be entered only for funct3=000, or funct3=001 with EN_BNE=1; any other funct3 SHALL go to ILLEGAL.
REQ-022 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=00 for load and 01 for store; next MEMREAD (load) or MEMWRITE (store).
REQ-023 MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready, then MEMWB.
REQ-024 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-025 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready; next FETCH.
REQ-026 EXEC_R: ALUSrcA=10, ALUSrcB=00; ALUControl from funct3: 000 add/sub, 010 slt, 110 or, 111 and; next ALUWB.
REQ-027 R-type funct3=000 SHALL select sub only when funct7[5]=1; other R-type funct3 values SHALL be illegal.
REQ-028 EXEC_I: ALUSrcA=10, ALUSrcB=01, ImmSrc=00; funct3 decoded as in REQ-026; funct3=000 SHALL always select add regardless of instr[30]; next ALUWB.
REQ-029 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-030 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-031 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=zero_flg for BEQ, PCWrite=!zero_flg for BNE; next FETCH.
REQ-032 ILLEGAL: illegal_instr=1, no write strobes; next FETCH.
REQ-033 Latency in cycles, each memory wait adding cycles: R/I 4, load 5, store 4, JAL 4, branch 3, illegal 3.

Reset
REQ-034 rst_n low SHALL force state to FETCH asynchronously and SHALL hold PCWrite, IRWrite, MemWrite, RegWrite and illegal_instr at 0 while low.
REQ-035 Reset asserted in any state, including mid-MEMWRITE, SHALL abort the instruction; after release the first active cycle SHALL be FETCH.

Verification
REQ-036 add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC_R(ALUControl=000),ALUWB(RegWrite=1); sub (0x402081B3) -> ALUControl=001.
REQ-037 lw (0x0040A183) with mem_ready low 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles, RegWrite=1 exactly once in MEMWB, total 7 cycles.
REQ-038 beq (0x00208463): zero_flg=1 -> PCWrite=1 in BRANCH; zero_flg=0 -> PCWrite=0; bne with EN_BNE=0 -> illegal_instr pulse.
REQ-039 opcode 0x7F -> DECODE->ILLEGAL, illegal_instr high one cycle, then FETCH, no write strobes.
REQ-040 sw (0x0020A223) with rst_n pulsed low during MEMWRITE -> MemWrite drops immediately, FETCH after release.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Moore control FSM for a multicycle RV32 subset datapath (load, store,
//   R-type ALU, I-type ALU, JAL, BEQ/BNE). One state per datapath step;
//   every control output is a function of the current state only, except the
//   memory-handshake strobes, which follow mem_ready, and the branch PC enable,
//   which follows zero_flg.
//
// Parameters
//   ALUCTRL_W : ALUControl width (>= 3), codes zero-extended
//   EN_BNE    : 1 = decode BNE (funct3 001), 0 = treat it as illegal
//   MEM_WAIT  : 1 = memory states wait on mem_ready, 0 = mem_ready ignored
//
// Ports
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   instr[31:0]      : instruction register, stable from DECODE to FETCH
//   zero_flg         : ALU zero result (branch compare)
//   mem_ready        : memory access completes this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc : datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc          : 2-bit mux selects
//   ALUControl       : ALU operation code
//   illegal_instr    : one-cycle pulse on an undecodable instruction
//   state_o[3:0]     : current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALUCTRL_W = 3,
    parameter bit EN_BNE    = 1'b1,
    parameter bit MEM_WAIT  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 zero_flg,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal_instr,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state, state_nxt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       ready;

    // Internal (ungated) strobes; the port versions are forced low in reset.
    logic       pc_write, ir_write, mem_write, reg_write, illegal;
    logic [2:0] alu_ctrl;

    // Instruction fields the controller never looks at.
    logic       unused_instr_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // With MEM_WAIT = 0 every memory access completes in its first cycle.
    assign ready = mem_ready | ~MEM_WAIT;

    // funct3 values the ALU can execute: add/sub, slt, or, and.
    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (EN_BNE && (f3 == 3'b001));
    endfunction

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // NOTE: only the state register is reset; outputs are combinational
    // decodes of it, so reset reaches them without extra flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = 2'b00;
        alu_ctrl  = ALU_ADD;

        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;        // PC + 4
                ResultSrc = 2'b10;
                ir_write  = ready;
                pc_write  = ready;
                if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (opcode)
                    7'b0000011,
                    7'b0100011: state_nxt = S_MEMADR;
                    7'b0110011: state_nxt = alu_f3_ok(funct3) ? S_EXEC_R : S_ILLEGAL;
                    7'b0010011: state_nxt = alu_f3_ok(funct3) ? S_EXEC_I : S_ILLEGAL;
                    7'b1101111: state_nxt = S_JAL;
                    7'b1100011: state_nxt = branch_f3_ok(funct3) ? S_BRANCH : S_ILLEGAL;
                    default:    state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                // opcode[5] separates store (0100011) from load (0000011).
                ImmSrc    = opcode[5] ? 2'b01 : 2'b00;
                state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (ready) state_nxt = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA   = 2'b10;
                alu_ctrl  = alu_decode(funct3, funct7_b5);
                state_nxt = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                // instr[30] is immediate data here, never a sub select.
                alu_ctrl  = alu_decode(funct3, 1'b0);
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                // Jump to the target held in ALUOut; ALU forms the link OldPC+4.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_write  = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = funct3[0] ? ~zero_flg : zero_flg;
                state_nxt = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal   = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // FETCH drives IRWrite/PCWrite from mem_ready, so the strobes are also
    // gated by rst_n to stay low for the whole time reset is held.
    assign PCWrite       = pc_write  & rst_n;
    assign IRWrite       = ir_write  & rst_n;
    assign MemWrite      = mem_write & rst_n;
    assign RegWrite      = reg_write & rst_n;
    assign illegal_instr = illegal   & rst_n;

    assign ALUControl = ALUCTRL_W'(alu_ctrl);
    assign state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Table-driven bench for multicycle_control. Each table row is one clock
//   cycle: the inputs for that cycle plus the expected state and the expected
//   control word {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,
//   ALUSrcB,ImmSrc,ALUControl,illegal_instr}. A second instance with
//   EN_BNE = 0 runs in lockstep and is checked on the BNE sequence; the
//   reset-during-store case is written out by hand.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXEC_R   = 4'd6;
    localparam logic [3:0] ST_EXEC_I   = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_JAL      = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_ILLEGAL  = 4'd11;

    // Expected control words, written out from the per-state output lists.
    //                                  strobes  res    srcA   srcB   imm    alu     ill
    localparam logic [16:0] C_FETCH    = {5'b11000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_FETCH_W  = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_DECODE   = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0};
    localparam logic [16:0] C_MEMADR_L = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_MEMADR_S = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0};
    localparam logic [16:0] C_MEMREAD  = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_MEMWB    = {5'b00010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_MEMWRITE = {5'b00101, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_ALUWB    = {5'b00010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_JAL      = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0};
    localparam logic [16:0] C_ILLEGAL  = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};

    function automatic logic [16:0] c_exec_r(input logic [2:0] alu);
        return {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, alu, 1'b0};
    endfunction

    function automatic logic [16:0] c_exec_i(input logic [2:0] alu);
        return {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, alu, 1'b0};
    endfunction

    function automatic logic [16:0] c_branch(input logic pcw);
        return {pcw, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic        zf;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctrl;
    } vec_t;

    vec_t vecs[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero_flg;
    logic        mem_ready;

    logic        pc_write, ir_write, mem_write, reg_write, adr_src, illegal_instr;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic [3:0]  state_o;

    logic        b_pc_write, b_ir_write, b_mem_write, b_reg_write, b_adr_src, b_illegal;
    logic [1:0]  b_result_src, b_alu_src_a, b_alu_src_b, b_imm_src;
    logic [2:0]  b_alu_control;
    logic [3:0]  b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ALUCTRL_W(3), .EN_BNE(1'b1), .MEM_WAIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero_flg(zero_flg), .mem_ready(mem_ready),
        .PCWrite(pc_write), .IRWrite(ir_write), .MemWrite(mem_write), .RegWrite(reg_write),
        .AdrSrc(adr_src), .ResultSrc(result_src), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
        .ImmSrc(imm_src), .ALUControl(alu_control), .illegal_instr(illegal_instr),
        .state_o(state_o)
    );

    multicycle_control #(.ALUCTRL_W(3), .EN_BNE(1'b0), .MEM_WAIT(1'b1)) dut_nobne (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero_flg(zero_flg), .mem_ready(mem_ready),
        .PCWrite(b_pc_write), .IRWrite(b_ir_write), .MemWrite(b_mem_write), .RegWrite(b_reg_write),
        .AdrSrc(b_adr_src), .ResultSrc(b_result_src), .ALUSrcA(b_alu_src_a), .ALUSrcB(b_alu_src_b),
        .ImmSrc(b_imm_src), .ALUControl(b_alu_control), .illegal_instr(b_illegal),
        .state_o(b_state)
    );

    function automatic logic [16:0] ctrl_word();
        return {pc_write, ir_write, mem_write, reg_write, adr_src, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic [31:0] i, input logic zf, input logic mr,
                           input logic [3:0] st, input logic [16:0] c);
        vec_t v;
        v.instr = i;
        v.zf    = zf;
        v.mr    = mr;
        v.st    = st;
        v.ctrl  = c;
        vecs.push_back(v);
    endtask

    task automatic seq_r(input logic [31:0] i, input logic [2:0] alu);
        add_row(i, 1'b0, 1'b1, ST_FETCH,  C_FETCH);
        add_row(i, 1'b0, 1'b1, ST_DECODE, C_DECODE);
        add_row(i, 1'b0, 1'b1, ST_EXEC_R, c_exec_r(alu));
        add_row(i, 1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
    endtask

    task automatic seq_i(input logic [31:0] i, input logic [2:0] alu);
        add_row(i, 1'b0, 1'b1, ST_FETCH,  C_FETCH);
        add_row(i, 1'b0, 1'b1, ST_DECODE, C_DECODE);
        add_row(i, 1'b0, 1'b1, ST_EXEC_I, c_exec_i(alu));
        add_row(i, 1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
    endtask

    task automatic seq_ill(input logic [31:0] i);
        add_row(i, 1'b0, 1'b1, ST_FETCH,   C_FETCH);
        add_row(i, 1'b0, 1'b1, ST_DECODE,  C_DECODE);
        add_row(i, 1'b0, 1'b1, ST_ILLEGAL, C_ILLEGAL);
    endtask

    initial begin
        // ---------------- vector table ----------------
        seq_r(32'h002081B3, 3'b000);            // add
        seq_r(32'h402081B3, 3'b001);            // sub
        seq_r(32'h0020A1B3, 3'b101);            // slt
        seq_r(32'h0020E1B3, 3'b011);            // or
        seq_r(32'h0020F1B3, 3'b010);            // and
        seq_i(32'h40108093, 3'b000);            // addi with instr[30]=1 stays add
        seq_i(32'h0010A093, 3'b101);            // slti
        seq_i(32'h0010E093, 3'b011);            // ori
        seq_i(32'h0010F093, 3'b010);            // andi
        // lw, two wait cycles in MEMREAD: 7 cycles total
        add_row(32'h0040A183, 1'b0, 1'b1, ST_FETCH,   C_FETCH);
        add_row(32'h0040A183, 1'b0, 1'b1, ST_DECODE,  C_DECODE);
        add_row(32'h0040A183, 1'b0, 1'b1, ST_MEMADR,  C_MEMADR_L);
        add_row(32'h0040A183, 1'b0, 1'b0, ST_MEMREAD, C_MEMREAD);
        add_row(32'h0040A183, 1'b0, 1'b0, ST_MEMREAD, C_MEMREAD);
        add_row(32'h0040A183, 1'b0, 1'b1, ST_MEMREAD, C_MEMREAD);
        add_row(32'h0040A183, 1'b0, 1'b1, ST_MEMWB,   C_MEMWB);
        // sw, fetch stall then one write wait
        add_row(32'h0020A223, 1'b0, 1'b0, ST_FETCH,    C_FETCH_W);
        add_row(32'h0020A223, 1'b0, 1'b1, ST_FETCH,    C_FETCH);
        add_row(32'h0020A223, 1'b0, 1'b1, ST_DECODE,   C_DECODE);
        add_row(32'h0020A223, 1'b0, 1'b1, ST_MEMADR,   C_MEMADR_S);
        add_row(32'h0020A223, 1'b0, 1'b0, ST_MEMWRITE, C_MEMWRITE);
        add_row(32'h0020A223, 1'b0, 1'b1, ST_MEMWRITE, C_MEMWRITE);
        // beq taken / not taken
        add_row(32'h00208463, 1'b1, 1'b1, ST_FETCH,  C_FETCH);
        add_row(32'h00208463, 1'b1, 1'b1, ST_DECODE, C_DECODE);
        add_row(32'h00208463, 1'b1, 1'b1, ST_BRANCH, c_branch(1'b1));
        add_row(32'h00208463, 1'b0, 1'b1, ST_FETCH,  C_FETCH);
        add_row(32'h00208463, 1'b0, 1'b1, ST_DECODE, C_DECODE);
        add_row(32'h00208463, 1'b0, 1'b1, ST_BRANCH, c_branch(1'b0));
        // jal
        add_row(32'h008000EF, 1'b0, 1'b1, ST_FETCH,  C_FETCH);
        add_row(32'h008000EF, 1'b0, 1'b1, ST_DECODE, C_DECODE);
        add_row(32'h008000EF, 1'b0, 1'b1, ST_JAL,    C_JAL);
        add_row(32'h008000EF, 1'b0, 1'b1, ST_ALUWB,  C_ALUWB);
        // illegal encodings: bad opcode, R-type sll, branch blt
        seq_ill(32'h0000007F);
        seq_ill(32'h002091B3);
        seq_ill(32'h0020C463);

        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        instr     = 32'h0;
        zero_flg  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset state", 32'(state_o), 32'(ST_FETCH));
        check("reset strobes", 32'({pc_write, ir_write, mem_write, reg_write, illegal_instr}), 32'h0);
        rst_n = 1'b1;

        // ---------------- table loop ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            instr     = vecs[i].instr;
            zero_flg  = vecs[i].zf;
            mem_ready = vecs[i].mr;
            #1;
            check($sformatf("row%0d state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("row%0d ctrl", i), 32'(ctrl_word()), 32'(vecs[i].ctrl));
            @(negedge clk);
        end

        // ---------------- bne: taken on EN_BNE=1, illegal on EN_BNE=0 ----------------
        instr     = 32'h00209463;
        zero_flg  = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bne state", 32'(state_o), 32'(ST_BRANCH));
        check("bne pcwrite", 32'(pc_write), 32'h1);
        check("bne off state", 32'(b_state), 32'(ST_ILLEGAL));
        check("bne off illegal", 32'(b_illegal), 32'h1);
        check("bne off strobes", 32'({b_pc_write, b_mem_write, b_reg_write}), 32'h0);
        @(negedge clk);
        #1;
        check("bne off illegal drop", 32'(b_illegal), 32'h0);
        check("bne off back to fetch", 32'(b_state), 32'(ST_FETCH));

        // ---------------- reset during MEMWRITE ----------------
        instr = 32'h0020A223;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("sw memwrite state", 32'(state_o), 32'(ST_MEMWRITE));
        check("sw memwrite high", 32'(mem_write), 32'h1);
        rst_n = 1'b0;
        #1;
        check("sw reset memwrite drop", 32'(mem_write), 32'h0);
        check("sw reset async state", 32'(state_o), 32'(ST_FETCH));
        mem_ready = 1'b1;
        @(negedge clk);
        check("sw reset held irwrite", 32'(ir_write), 32'h0);
        rst_n = 1'b1;
        #1;
        check("after release state", 32'(state_o), 32'(ST_FETCH));
        check("after release irwrite", 32'(ir_write), 32'h1);
        @(negedge clk);
        check("after release decode", 32'(state_o), 32'(ST_DECODE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
